scoreboard: RTL

SCOREBOARD -- requirements
Module: scoreboard

---
 rtl/rv32i_pkg.sv | 31 +++
 rtl/scoreboard_entry.sv | 75 +++++++
 rtl/scoreboard.sv | 108 ++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared definitions for the register scoreboard.
//   NUM_REGS      architectural register count (x0 is hard-wired zero)
//   DEF_CNT_W     default width of each per-register in-flight writer counter
//   REG_IDX_W     register index width
//   sb_event_t    one issue or writeback event: valid, reg_write, is_load, rd
//   iss_hit()     true when an issue event targets register r
//   wb_hit()      true when a writeback event targets register r
package rv32i_pkg;

  localparam int NUM_REGS  = 32;
  localparam int DEF_CNT_W = 2;
  localparam int REG_IDX_W = 5;

  typedef struct packed {
    logic                 valid;
    logic                 reg_write;
    logic                 is_load;
    logic [REG_IDX_W-1:0] rd;
  } sb_event_t;

  // An issue only counts if it actually writes a register other than x0.
  function automatic logic iss_hit(input sb_event_t ev, input logic [REG_IDX_W-1:0] r);
    return ev.valid && ev.reg_write && (ev.rd != '0) && (ev.rd == r);
  endfunction

  // Writebacks carry no reg_write qualifier; rd=0 is ignored.
  function automatic logic wb_hit(input sb_event_t ev, input logic [REG_IDX_W-1:0] r);
    return ev.valid && (ev.rd != '0) && (ev.rd == r);
  endfunction

endpackage

// File: rtl/scoreboard_entry.sv
// One register's scoreboard state: in-flight writer counter plus load bit.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   flush         pipeline redirect; only pending loads survive it
//   iss_cnt       number of issue events hitting this register (0..2)
//   iss_load      at least one of those issues is a load
//   wb_cnt        number of writeback events hitting this register (0..2)
//   wb_load       at least one of those writebacks is a load
//   busy          counter is non-zero (registered)
//   load_pending  a load to this register is outstanding (registered)
//   err_pulse     this cycle's update overflowed or underflowed (combinational)
module scoreboard_entry #(
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic [1:0] iss_cnt,
  input  logic       iss_load,
  input  logic [1:0] wb_cnt,
  input  logic       wb_load,
  output logic       busy,
  output logic       load_pending,
  output logic       err_pulse
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             load_q;
  logic             load_next;
  // Two extra bits: one for the +2 headroom, one as the sign of a -2 result.
  logic [CNT_W+1:0] sum;

  always_comb begin
    sum       = {2'b00, cnt} + {{CNT_W{1'b0}}, iss_cnt} - {{CNT_W{1'b0}}, wb_cnt};
    cnt_next  = cnt;
    load_next = load_q;
    err_pulse = 1'b0;
    if (flush) begin
      // Issues are dropped; writebacks still retire the load bit. Whatever
      // load survives is the single remaining writer.
      load_next = load_q && !wb_load;
      cnt_next  = load_next ? CNT_W'(1) : '0;
    end else begin
      if (sum[CNT_W+1]) begin
        cnt_next  = '0;
        err_pulse = 1'b1;
      end else if (sum[CNT_W]) begin
        cnt_next  = '1;
        err_pulse = 1'b1;
      end else begin
        cnt_next  = sum[CNT_W-1:0];
      end
      // Set beats clear; a counter reaching zero always drops the load bit.
      load_next = iss_load || (load_q && !wb_load);
      if (cnt_next == '0) begin
        load_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      load_q <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      load_q <= load_next;
    end
  end

  assign busy         = (cnt != '0);
  assign load_pending = load_q;

endmodule

// File: rtl/scoreboard.sv
// Register scoreboard for a dual-issue, dual-writeback pipeline.
// Tracks how many writers are in flight per register and which registers
// await a load. All outputs come from registered state.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush                     redirect: kills in-flight non-load producers
//   iss0_* / iss1_*           issue events (valid, reg_write, is_load, rd)
//   wb0_* / wb1_*             writeback events (valid, is_load, rd)
//   busy_vec                  bit r: register r has an in-flight writer
//   load_pending_vec          bit r: an issued load to r has not written back
//   sb_error                  sticky counter overflow/underflow flag
module scoreboard
  import rv32i_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int NUM_REGS = rv32i_pkg::NUM_REGS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        iss0_valid,
  input  logic        iss0_reg_write,
  input  logic        iss0_is_load,
  input  logic [4:0]  iss0_rd,
  input  logic        iss1_valid,
  input  logic        iss1_reg_write,
  input  logic        iss1_is_load,
  input  logic [4:0]  iss1_rd,
  input  logic        wb0_valid,
  input  logic        wb0_is_load,
  input  logic [4:0]  wb0_rd,
  input  logic        wb1_valid,
  input  logic        wb1_is_load,
  input  logic [4:0]  wb1_rd,
  output logic [31:0] busy_vec,
  output logic [31:0] load_pending_vec,
  output logic        sb_error
);

  sb_event_t iss0, iss1, wb0, wb1;

  assign iss0 = '{valid: iss0_valid, reg_write: iss0_reg_write, is_load: iss0_is_load, rd: iss0_rd};
  assign iss1 = '{valid: iss1_valid, reg_write: iss1_reg_write, is_load: iss1_is_load, rd: iss1_rd};
  // Writebacks always write; reg_write is forced so the struct stays uniform.
  assign wb0  = '{valid: wb0_valid, reg_write: 1'b1, is_load: wb0_is_load, rd: wb0_rd};
  assign wb1  = '{valid: wb1_valid, reg_write: 1'b1, is_load: wb1_is_load, rd: wb1_rd};

  logic [31:1][1:0] iss_cnt;
  logic [31:1]      iss_load;
  logic [31:1][1:0] wb_cnt;
  logic [31:1]      wb_load;
  logic [31:1]      err_pulse;
  logic [31:1]      busy_bits;
  logic [31:1]      load_bits;

  // Per-register hit decode for both issue slots and both writeback ports.
  always_comb begin
    iss_cnt  = '0;
    iss_load = '0;
    wb_cnt   = '0;
    wb_load  = '0;
    for (int r = 1; r < 32; r++) begin
      logic h_i0, h_i1, h_w0, h_w1;
      h_i0 = iss_hit(iss0, 5'(r));
      h_i1 = iss_hit(iss1, 5'(r));
      h_w0 = wb_hit(wb0, 5'(r));
      h_w1 = wb_hit(wb1, 5'(r));
      iss_cnt[r]  = {1'b0, h_i0} + {1'b0, h_i1};
      iss_load[r] = (h_i0 && iss0.is_load) || (h_i1 && iss1.is_load);
      wb_cnt[r]   = {1'b0, h_w0} + {1'b0, h_w1};
      wb_load[r]  = (h_w0 && wb0.is_load) || (h_w1 && wb1.is_load);
    end
  end

  for (genvar r = 1; r < 32; r++) begin : g_entry
    if (r < NUM_REGS) begin : g_live
      scoreboard_entry #(.CNT_W(CNT_W)) u_entry (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .iss_cnt      (iss_cnt[r]),
        .iss_load     (iss_load[r]),
        .wb_cnt       (wb_cnt[r]),
        .wb_load      (wb_load[r]),
        .busy         (busy_bits[r]),
        .load_pending (load_bits[r]),
        .err_pulse    (err_pulse[r])
      );
    end else begin : g_absent
      assign busy_bits[r] = 1'b0;
      assign load_bits[r] = 1'b0;
      assign err_pulse[r] = 1'b0;
    end
  end

  // x0 is never tracked.
  assign busy_vec         = {busy_bits, 1'b0};
  assign load_pending_vec = {load_bits, 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_error <= 1'b0;
    end else if (|err_pulse) begin
      sb_error <= 1'b1;
    end
  end

endmodule
